// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: CRC-32 byte step, framing constants and the
// receive state encoding.
package eth_pkg;

    localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

    // MSB-first register, data bits consumed LSB first (Ethernet wire order).
    function automatic logic [31:0] NextCRC(input logic [7:0] D, input logic [31:0] C);
        logic [31:0] c;
        logic        fb;
        c = C;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[31] ^ D[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Registered byte-wide CRC-32 accumulator; residue_ok flags a frame whose
// FCS bytes have been folded in and check out.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc,
    output logic        residue_ok
);

    always_ff @(posedge clk) begin
        if (rst || init) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= NextCRC(data, crc);
        end
    end

    assign residue_ok = (crc == CRC_RESIDUE);

endmodule

// File: rtl/gmii_rx_frame_check.sv
// GMII receive framer: strips preamble/SFD and FCS, streams the payload with
// sop/eop, checks CRC-32 and length, and counts good and bad frames.
module gmii_rx_frame_check
    import eth_pkg::*;
#(
    parameter int unsigned MIN_LEN = 60,
    parameter int unsigned MAX_LEN = 1514,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_dat,
    input  logic             rx_dv,
    input  logic             rx_er,
    output logic [7:0]       out_dat,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_crc_err,
    output logic             out_len_err,
    output logic             out_phy_err,
    output logic [15:0]      out_len,
    output logic [CNT_W-1:0] frames_ok,
    output logic [CNT_W-1:0] frames_bad
);

    // byte_cnt counts post-SFD bytes, FCS included, so payload = byte_cnt - 4.
    localparam logic [15:0] OUT_CNT  = 16'd5;
    localparam logic [15:0] MIN_CNT  = 16'(MIN_LEN + 4);
    localparam logic [15:0] MAX_CNT  = 16'(MAX_LEN + 4);
    localparam logic [15:0] CNT_SAT  = 16'(MAX_LEN + 5);

    rx_state_t       state, state_next;
    logic            armed;
    logic [15:0]     byte_cnt;
    logic [4:0][7:0] dly;
    logic [7:0]      held;
    logic            phy_err;

    logic            crc_init, crc_en;
    logic            frame_end, drop_end;
    logic            residue_ok;
    logic [31:0]     crc_unused;
    logic            runt, over, frame_bad;

    eth_crc32_byte u_crc (
        .clk        (clk),
        .rst        (rst),
        .init       (crc_init),
        .en         (crc_en),
        .data       (rx_dat),
        .crc        (crc_unused),
        .residue_ok (residue_ok)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        crc_init   = 1'b0;
        crc_en     = 1'b0;
        frame_end  = 1'b0;
        drop_end   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_dv && armed) begin
                    if (!rx_er && rx_dat == PREAMBLE_BYTE) begin
                        state_next = ST_PREAMBLE;
                    end else begin
                        state_next = ST_DROP;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!rx_dv) begin
                    state_next = ST_IDLE;
                    drop_end   = 1'b1;
                end else if (rx_er) begin
                    state_next = ST_DROP;
                end else if (rx_dat == SFD_BYTE) begin
                    state_next = ST_DATA;
                    crc_init   = 1'b1;
                end else if (rx_dat != PREAMBLE_BYTE) begin
                    state_next = ST_DROP;
                end
            end
            ST_DATA: begin
                if (rx_dv) begin
                    crc_en = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    frame_end  = 1'b1;
                end
            end
            ST_DROP: begin
                if (!rx_dv) begin
                    state_next = ST_IDLE;
                    drop_end   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign runt      = (byte_cnt < MIN_CNT);
    assign over      = (byte_cnt > MAX_CNT);
    assign frame_bad = !residue_ok || runt || over || phy_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b0;
            byte_cnt    <= '0;
            dly         <= '0;
            held        <= '0;
            phy_err     <= 1'b0;
            out_dat     <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_crc_err <= 1'b0;
            out_len_err <= 1'b0;
            out_phy_err <= 1'b0;
            out_len     <= '0;
            frames_ok   <= '0;
            frames_bad  <= '0;
        end else begin
            out_dat     <= '0;
            out_valid   <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_crc_err <= 1'b0;
            out_len_err <= 1'b0;
            out_phy_err <= 1'b0;
            out_len     <= '0;

            if (!rx_dv) begin
                armed <= 1'b1;
            end

            if (crc_init) begin
                byte_cnt <= '0;
                phy_err  <= 1'b0;
            end

            if (crc_en) begin
                dly <= {dly[3:0], rx_dat};
                if (byte_cnt != CNT_SAT) begin
                    byte_cnt <= byte_cnt + 16'd1;
                end
                if (rx_er) begin
                    phy_err <= 1'b1;
                end
                // Byte MAX_LEN-1 is parked in held so an oversize frame can
                // still close with it as the eop beat once rx_dv drops.
                if (byte_cnt >= OUT_CNT && byte_cnt < MAX_CNT) begin
                    out_valid <= 1'b1;
                    out_dat   <= dly[4];
                    out_sop   <= (byte_cnt == OUT_CNT);
                end else if (byte_cnt == MAX_CNT) begin
                    held <= dly[4];
                end
            end

            if (frame_end) begin
                if (byte_cnt >= OUT_CNT) begin
                    out_valid   <= 1'b1;
                    out_eop     <= 1'b1;
                    out_sop     <= (byte_cnt == OUT_CNT);
                    out_dat     <= over ? held : dly[4];
                    out_crc_err <= !residue_ok;
                    out_len_err <= runt || over;
                    out_phy_err <= phy_err;
                    out_len     <= byte_cnt - 16'd4;
                    if (frame_bad) begin
                        frames_bad <= frames_bad + CNT_W'(1);
                    end else begin
                        frames_ok <= frames_ok + CNT_W'(1);
                    end
                end else begin
                    frames_bad <= frames_bad + CNT_W'(1);
                end
            end else if (drop_end) begin
                frames_bad <= frames_bad + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gmii_rx_frame_check.sv
// Directed bench for gmii_rx_frame_check: builds GMII frames with a
// reflected CRC-32 reference and checks payload, framing and status.
module tb_gmii_rx_frame_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  rx_dat = '0;
    logic [7:0]  out_dat;
    logic        out_valid, out_sop, out_eop;
    logic        out_crc_err, out_len_err, out_phy_err;
    logic [15:0] out_len;
    logic [31:0] frames_ok, frames_bad;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_ok = '0;
    logic [31:0] exp_bad = '0;

    logic [7:0]  cap[$];
    int          sop_cnt, sop_pos, eop_cnt, eop_pos, stray;
    logic        st_crc, st_len, st_phy;
    logic [15:0] st_olen;

    gmii_rx_frame_check #(.MIN_LEN(60), .MAX_LEN(1514), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .rx_dat(rx_dat), .rx_dv(rx_dv), .rx_er(rx_er),
        .out_dat(out_dat), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
        .out_crc_err(out_crc_err), .out_len_err(out_len_err), .out_phy_err(out_phy_err),
        .out_len(out_len), .frames_ok(frames_ok), .frames_bad(frames_bad)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid) begin
            if (out_sop) begin sop_cnt++; sop_pos = cap.size(); end
            if (out_eop) begin
                eop_cnt++; eop_pos = cap.size();
                st_crc = out_crc_err; st_len = out_len_err; st_phy = out_phy_err; st_olen = out_len;
            end
            cap.push_back(out_dat);
        end else if (out_sop || out_eop) begin
            stray++;
        end
    end

    function automatic logic [7:0] pay(input int i, input int mul);
        return 8'(i * mul);
    endfunction

    // Standard reflected Ethernet CRC-32 (final value, already inverted).
    function automatic logic [31:0] crc_ref(input int len, input int mul);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            r = r ^ {24'h0, pay(i, mul)};
            for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return ~r;
    endfunction

    function automatic int first_diff(input int mul);
        for (int i = 0; i < cap.size(); i++) if (cap[i] !== pay(i, mul)) return i;
        return -1;
    endfunction

    task automatic put(input logic dv, input logic er, input logic [7:0] d);
        rx_dv = dv; rx_er = er; rx_dat = d;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) put(1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_cap();
        cap.delete();
        sop_cnt = 0; sop_pos = -1; eop_cnt = 0; eop_pos = -1; stray = 0;
        st_crc = 1'b0; st_len = 1'b0; st_phy = 1'b0; st_olen = '0;
    endtask

    // Sends preamble, SFD, payload, FCS (optionally one byte inverted) and one idle cycle.
    task automatic send_frame(input int len, input int mul, input int fcs_flip, input int er_idx,
                              input int rst_idx, input int pre_len, input logic [7:0] sfd);
        logic [31:0] r;
        logic [7:0]  b;
        r = crc_ref(len, mul);
        for (int i = 0; i < pre_len; i++) put(1'b1, 1'b0, 8'h55);
        put(1'b1, 1'b0, sfd);
        for (int i = 0; i < len; i++) begin
            if (i == rst_idx) rst = 1'b1;
            put(1'b1, i == er_idx, pay(i, mul));
            rst = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            b = r[8*k +: 8];
            if (k == fcs_flip) b = ~b;
            put(1'b1, 1'b0, b);
        end
        idle(1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_cmp++; if ({out_valid, out_sop, out_eop, out_crc_err, out_len_err, out_phy_err} !== 6'b0 || out_dat !== 8'h00 || out_len !== 16'h0)
            begin n_bad++; $display("FAIL reset_outputs: got v%b s%b e%b dat %h len %0d want all 0", out_valid, out_sop, out_eop, out_dat, out_len); end
        n_cmp++; if (frames_ok !== 32'd0 || frames_bad !== 32'd0)
            begin n_bad++; $display("FAIL reset_counters: got ok %0d bad %0d want 0/0", frames_ok, frames_bad); end
        rst = 1'b0;
        idle(2);
        exp_ok = '0; exp_bad = '0;
    endtask

    task automatic test_good_frame(input string nm, input int len, input int mul);
        int d;
        clear_cap();
        send_frame(len, mul, -1, -1, -1, 7, 8'hD5);
        idle(2);
        exp_ok++;
        d = first_diff(mul);
        n_cmp++; if (cap.size() !== len) begin n_bad++; $display("FAIL %s_beats: got %0d want %0d", nm, cap.size(), len); end
        n_cmp++; if (d != -1) begin n_bad++; $display("FAIL %s_data: byte %0d got %h want %h", nm, d, cap[d], pay(d, mul)); end
        n_cmp++; if (sop_cnt !== 1 || sop_pos !== 0 || stray !== 0) begin n_bad++; $display("FAIL %s_sop: got cnt %0d pos %0d stray %0d want 1/0/0", nm, sop_cnt, sop_pos, stray); end
        n_cmp++; if (eop_cnt !== 1 || eop_pos !== len - 1) begin n_bad++; $display("FAIL %s_eop: got cnt %0d pos %0d want 1/%0d", nm, eop_cnt, eop_pos, len - 1); end
        n_cmp++; if ({st_crc, st_len, st_phy} !== 3'b000) begin n_bad++; $display("FAIL %s_status: got crc%b len%b phy%b want 000", nm, st_crc, st_len, st_phy); end
        n_cmp++; if (st_olen !== 16'(len)) begin n_bad++; $display("FAIL %s_len: got %0d want %0d", nm, st_olen, len); end
        n_cmp++; if (frames_ok !== exp_ok || frames_bad !== exp_bad) begin n_bad++; $display("FAIL %s_counters: got ok %0d bad %0d want %0d/%0d", nm, frames_ok, frames_bad, exp_ok, exp_bad); end
    endtask

    task automatic test_crc_error();
        int d;
        clear_cap();
        send_frame(64, 1, 2, -1, -1, 7, 8'hD5);
        idle(2);
        exp_bad++;
        d = first_diff(1);
        n_cmp++; if (cap.size() !== 64 || d != -1) begin n_bad++; $display("FAIL crc_payload: got %0d beats first diff %0d want 64 / -1", cap.size(), d); end
        n_cmp++; if (eop_cnt !== 1 || eop_pos !== 63) begin n_bad++; $display("FAIL crc_eop: got cnt %0d pos %0d want 1/63", eop_cnt, eop_pos); end
        n_cmp++; if ({st_crc, st_len, st_phy} !== 3'b100) begin n_bad++; $display("FAIL crc_status: got crc%b len%b phy%b want 100", st_crc, st_len, st_phy); end
        n_cmp++; if (frames_ok !== exp_ok || frames_bad !== exp_bad) begin n_bad++; $display("FAIL crc_counters: got ok %0d bad %0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); end
    endtask

    task automatic test_short_frames();
        int d;
        clear_cap();
        send_frame(10, 3, -1, -1, -1, 7, 8'hD5);
        idle(2);
        exp_bad++;
        d = first_diff(3);
        n_cmp++; if (cap.size() !== 10 || d != -1) begin n_bad++; $display("FAIL len10_payload: got %0d beats first diff %0d want 10 / -1", cap.size(), d); end
        n_cmp++; if (eop_cnt !== 1 || eop_pos !== 9 || sop_pos !== 0) begin n_bad++; $display("FAIL len10_framing: got eop %0d@%0d sop@%0d want 1@9 sop@0", eop_cnt, eop_pos, sop_pos); end
        n_cmp++; if ({st_crc, st_len, st_phy} !== 3'b010 || st_olen !== 16'd10) begin n_bad++; $display("FAIL len10_status: got crc%b len%b phy%b len %0d want 010 len 10", st_crc, st_len, st_phy, st_olen); end

        clear_cap();
        send_frame(1, 1, -1, -1, -1, 7, 8'hD5);
        idle(2);
        exp_bad++;
        n_cmp++; if (cap.size() !== 1 || sop_pos !== 0 || eop_pos !== 0 || cap[0] !== 8'h00) begin n_bad++; $display("FAIL len1_beat: got %0d beats sop@%0d eop@%0d want 1 beat 00 sop@0 eop@0", cap.size(), sop_pos, eop_pos); end
        n_cmp++; if ({st_crc, st_len} !== 2'b01 || st_olen !== 16'd1) begin n_bad++; $display("FAIL len1_status: got crc%b len%b len %0d want 01 len 1", st_crc, st_len, st_olen); end

        clear_cap();
        send_frame(0, 1, -1, -1, -1, 7, 8'hD5);
        idle(2);
        exp_bad++;
        n_cmp++; if (cap.size() !== 0 || eop_cnt !== 0 || stray !== 0) begin n_bad++; $display("FAIL len0_output: got %0d beats %0d eops %0d stray want none", cap.size(), eop_cnt, stray); end
        n_cmp++; if (frames_ok !== exp_ok || frames_bad !== exp_bad) begin n_bad++; $display("FAIL short_counters: got ok %0d bad %0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); end
    endtask

    task automatic test_oversize();
        int d;
        clear_cap();
        send_frame(1516, 7, -1, -1, -1, 7, 8'hD5);
        idle(2);
        exp_bad++;
        d = first_diff(7);
        n_cmp++; if (cap.size() !== 1514 || d != -1) begin n_bad++; $display("FAIL over_payload: got %0d beats first diff %0d want 1514 / -1", cap.size(), d); end
        n_cmp++; if (eop_cnt !== 1 || eop_pos !== 1513) begin n_bad++; $display("FAIL over_eop: got cnt %0d pos %0d want 1/1513", eop_cnt, eop_pos); end
        n_cmp++; if ({st_crc, st_len, st_phy} !== 3'b010 || st_olen !== 16'd1515) begin n_bad++; $display("FAIL over_status: got crc%b len%b phy%b len %0d want 010 len 1515", st_crc, st_len, st_phy, st_olen); end
        n_cmp++; if (frames_ok !== exp_ok || frames_bad !== exp_bad) begin n_bad++; $display("FAIL over_counters: got ok %0d bad %0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); end
    endtask

    task automatic test_back_to_back();
        int d;
        clear_cap();
        send_frame(20, 3, -1, -1, -1, 7, 8'h5D);
        send_frame(64, 5, -1, -1, -1, 7, 8'hD5);
        idle(2);
        exp_bad++; exp_ok++;
        d = first_diff(5);
        n_cmp++; if (cap.size() !== 64 || d != -1) begin n_bad++; $display("FAIL b2b_payload: got %0d beats first diff %0d want 64 / -1", cap.size(), d); end
        n_cmp++; if (eop_cnt !== 1 || sop_cnt !== 1 || {st_crc, st_len, st_phy} !== 3'b000) begin n_bad++; $display("FAIL b2b_framing: got eop %0d sop %0d status %b want 1 1 000", eop_cnt, sop_cnt, {st_crc, st_len, st_phy}); end
        n_cmp++; if (frames_ok !== exp_ok || frames_bad !== exp_bad) begin n_bad++; $display("FAIL b2b_counters: got ok %0d bad %0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); end
    endtask

    task automatic test_phy_error();
        int d;
        clear_cap();
        send_frame(64, 1, -1, 20, -1, 7, 8'hD5);
        idle(2);
        exp_bad++;
        d = first_diff(1);
        n_cmp++; if (cap.size() !== 64 || d != -1) begin n_bad++; $display("FAIL phy_payload: got %0d beats first diff %0d want 64 / -1", cap.size(), d); end
        n_cmp++; if ({st_crc, st_len, st_phy} !== 3'b001 || st_olen !== 16'd64) begin n_bad++; $display("FAIL phy_status: got crc%b len%b phy%b len %0d want 001 len 64", st_crc, st_len, st_phy, st_olen); end
        n_cmp++; if (frames_ok !== exp_ok || frames_bad !== exp_bad) begin n_bad++; $display("FAIL phy_counters: got ok %0d bad %0d want %0d/%0d", frames_ok, frames_bad, exp_ok, exp_bad); end
    endtask

    task automatic test_reset_mid_frame();
        clear_cap();
        send_frame(64, 1, -1, -1, 30, 7, 8'hD5);
        idle(2);
        exp_ok = '0; exp_bad = '0;
        n_cmp++; if (eop_cnt !== 0 || stray !== 0) begin n_bad++; $display("FAIL rstmid_eop: got %0d eops %0d stray want 0/0", eop_cnt, stray); end
        n_cmp++; if (frames_ok !== 32'd0 || frames_bad !== 32'd0) begin n_bad++; $display("FAIL rstmid_counters: got ok %0d bad %0d want 0/0", frames_ok, frames_bad); end
        test_good_frame("after_rst", 64, 1);
    endtask

    initial begin
        test_reset();
        test_good_frame("good64", 64, 1);
        test_crc_error();
        test_short_frames();
        test_good_frame("min60", 60, 9);
        test_good_frame("max1514", 1514, 11);
        test_oversize();
        test_back_to_back();
        test_phy_error();
        rst = 1'b1; idle(1); rst = 1'b0; idle(1);
        exp_ok = '0; exp_bad = '0;
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
